// File: rtl/vga_text_pkg.sv
// Shared timing constants and controller state encoding for the VGA text-mode
// controller. The 800x525 raster timing is fixed here; only the visible area is a parameter.
package vga_text_pkg;

    localparam int H_TOTAL      = 800;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_TOTAL      = 525;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    localparam logic [7:0] CHAR_BLANK = 8'h20;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/vga_text_ctrl_text_ram.sv
// Character store: one write port and one registered read port.
// The read port is read-first: a same-edge write to the read address returns the old byte.
module text_ram #(
    parameter int DEPTH = 4800,
    parameter int AW    = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_reg <= mem[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/vga_text_ctrl.sv
// VGA text-mode controller: raster counters, character-cell lookup and a screen-clear engine.
// Every display output is delayed one cycle so it lines up with the registered RAM read.
module vga_text_ctrl
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int COLS     = 80,
    parameter int ROWS     = 60
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        wr_en,
    input  logic [12:0] wr_addr,
    input  logic [7:0]  wr_data,
    input  logic        clear_req,
    output logic        busy,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic        frame_start,
    output logic [7:0]  ascii,
    output logic [9:0]  x,
    output logic [9:0]  y
);

    localparam int          DEPTH     = COLS * ROWS;
    localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

    logic [9:0]  h_cnt_reg, v_cnt_reg;
    logic        active;
    logic [12:0] rd_addr;
    logic [7:0]  ram_rdata;

    logic        valid_reg, hsync_reg, vsync_reg, frame_start_reg;
    logic [2:0]  x_reg, y_reg;

    state_t      state_reg, state_next;
    logic [12:0] clr_cnt_reg, clr_cnt_next;
    logic        ram_we;
    logic [12:0] ram_waddr;
    logic [7:0]  ram_wdata;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else if (h_cnt_reg == 10'(H_TOTAL - 1)) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= (v_cnt_reg == 10'(V_TOTAL - 1)) ? '0 : v_cnt_reg + 10'd1;
        end else begin
            h_cnt_reg <= h_cnt_reg + 10'd1;
        end
    end

    assign active = (h_cnt_reg < 10'(H_ACTIVE)) && (v_cnt_reg < 10'(V_ACTIVE));

    // Blanking pixels read cell 0 so the RAM address never leaves the array.
    assign rd_addr = active ? (({3'b000, v_cnt_reg} >> 3) * 13'(COLS) + ({3'b000, h_cnt_reg} >> 3))
                            : '0;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            valid_reg       <= 1'b0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            frame_start_reg <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
        end else begin
            valid_reg       <= active;
            hsync_reg       <= !((h_cnt_reg >= 10'(H_SYNC_START)) && (h_cnt_reg <= 10'(H_SYNC_END)));
            vsync_reg       <= !((v_cnt_reg >= 10'(V_SYNC_START)) && (v_cnt_reg <= 10'(V_SYNC_END)));
            frame_start_reg <= (h_cnt_reg == 10'd0) && (v_cnt_reg == 10'd0);
            x_reg           <= active ? h_cnt_reg[2:0] : 3'd0;
            y_reg           <= active ? v_cnt_reg[2:0] : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_reg   <= ST_IDLE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        ram_we       = 1'b0;
        ram_waddr    = wr_addr;
        ram_wdata    = wr_data;
        case (state_reg)
            ST_IDLE: begin
                ram_we = wr_en && (wr_addr < 13'(DEPTH));
                if (clear_req) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                // Host writes and further clear requests are ignored until the sweep ends.
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_reg;
                ram_wdata = CHAR_BLANK;
                if (clr_cnt_reg == LAST_ADDR) begin
                    state_next   = ST_IDLE;
                    clr_cnt_next = '0;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 13'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    text_ram #(
        .DEPTH (DEPTH),
        .AW    (13)
    ) u_text_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    assign busy        = (state_reg == ST_CLEAR);
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign valid       = valid_reg;
    assign frame_start = frame_start_reg;
    assign ascii       = valid_reg ? ram_rdata : 8'h00;
    assign x           = {7'd0, x_reg};
    assign y           = {7'd0, y_reg};

endmodule

// File: tb/tb_vga_text_ctrl.sv
// Bench for vga_text_ctrl: a raster/memory model derived from pixel arithmetic is compared
// against the DUT every cycle, with a few literal pixel expectations pinning the model.
module tb_vga_text_ctrl;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        wr_en = 1'b0;
    logic [12:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic        clear_req = 1'b0;
    logic        busy, hsync, vsync, valid, frame_start;
    logic [7:0]  ascii;
    logic [9:0]  x, y;

    always #5 clk = ~clk;

    vga_text_ctrl dut (
        .clk         (clk),
        .clrn        (clrn),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .clear_req   (clear_req),
        .busy        (busy),
        .hsync       (hsync),
        .vsync       (vsync),
        .valid       (valid),
        .frame_start (frame_start),
        .ascii       (ascii),
        .x           (x),
        .y           (y)
    );

    int checks = 0;
    int fails  = 0;

    // Model state: cycles since reset release, screen contents, pending clear sweep.
    int          t_model = 0;
    logic [7:0]  mem_m [4800];
    bit          known_m [4800];
    int          clr_left = 0;
    int          clr_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t_model);
        end
    endtask

    // Per-cycle model and compare process.
    int         h_m, v_m, addr_m;
    bit         act_m, known_a;
    logic [7:0] e_ascii;
    logic [32:0] e_ctrl;

    always @(posedge clk) begin
        if (!clrn) begin
            t_model  = 0;
            clr_left = 0;
            clr_idx  = 0;
            e_ctrl   = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 10'd0, 10'd0};
            #1;
            check("reset_outputs", 64'({hsync, vsync, valid, frame_start, busy, ascii, x, y}), 64'(e_ctrl));
        end else begin
            h_m    = t_model % 800;
            v_m    = (t_model / 800) % 525;
            act_m  = (h_m < 640) && (v_m < 480);
            addr_m = (v_m / 8) * 80 + (h_m / 8);
            e_ascii = act_m ? mem_m[addr_m] : 8'h00;
            known_a = !act_m || known_m[addr_m];
            if (clr_left > 0) begin
                mem_m[clr_idx]   = 8'h20;
                known_m[clr_idx] = 1'b1;
                clr_idx++;
                clr_left--;
            end else begin
                if (wr_en && (wr_addr < 13'd4800)) begin
                    mem_m[wr_addr]   = wr_data;
                    known_m[wr_addr] = 1'b1;
                end
                if (clear_req) begin
                    clr_left = 4800;
                    clr_idx  = 0;
                end
            end
            e_ctrl = {!(h_m >= 656 && h_m <= 751), !(v_m >= 490 && v_m <= 491), act_m,
                      (h_m == 0 && v_m == 0), (clr_left > 0), 8'h00,
                      act_m ? 10'(h_m % 8) : 10'd0, act_m ? 10'(v_m % 8) : 10'd0};
            t_model++;
            #1;
            check("raster", 64'({hsync, vsync, valid, frame_start, busy, 8'h00, x, y}), 64'(e_ctrl));
            if (known_a) check("ascii", 64'(ascii), 64'(e_ascii));
        end
    end

    task automatic wait_out(input int t_px);
        int n = 0;
        while (t_model != t_px + 1 && n < 100000) begin
            @(negedge clk);
            n++;
        end
        if (t_model != t_px + 1) begin
            checks++;
            fails++;
            $display("FAIL wait_timeout: got t=%0d expected t=%0d", t_model, t_px + 1);
        end
    endtask

    task automatic do_write(input logic [12:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        $display("write addr=%0d data=%02h t=%0d", a, d, t_model);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        $display("clear request t=%0d", t_model);
    endtask

    initial begin
        int lowc, cnt, n;
        logic [12:0] ra;
        repeat (4) @(negedge clk);
        check("reset_literal", 64'({hsync, vsync, valid, frame_start, busy, ascii, x, y}),
              64'({1'b1, 1'b1, 31'd0}));
        clrn = 1'b1;
        @(negedge clk);
        check("first_frame_start", 64'(frame_start), 64'd1);

        do_write(13'd0, 8'h41);
        do_write(13'd81, 8'h42);
        do_write(13'd4800, 8'h44);

        wait_out(2 * 800 + 3);
        check("pix_3_2", 64'({ascii, x, y}), 64'({8'h41, 10'd3, 10'd2}));
        lowc = 0;
        repeat (800) begin
            @(negedge clk);
            if (!hsync) lowc++;
        end
        check("hsync_low_per_line", 64'(lowc), 64'd96);
        wait_out(3 * 800 + 700);
        check("blank_h700", 64'({valid, ascii, x, y}), 64'd0);
        wait_out(9 * 800 + 10);
        check("pix_10_9", 64'({ascii, x, y}), 64'({8'h42, 10'd2, 10'd1}));

        // Clear sweep with ignored host write and ignored re-request while busy.
        pulse_clear();
        cnt = 0;
        n = 0;
        while (busy && n < 10000) begin
            cnt++;
            if (cnt == 200) clear_req = 1'b1;
            if (cnt == 201) clear_req = 1'b0;
            if (cnt == 4700) begin wr_en = 1'b1; wr_addr = 13'd300; wr_data = 8'h55; end
            if (cnt == 4701) wr_en = 1'b0;
            @(negedge clk);
            n++;
        end
        check("busy_cycles", 64'(cnt), 64'd4800);
        $display("clear done busy_cycles=%0d t=%0d", cnt, t_model);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            if ($urandom_range(0, 4) == 0) ra = 13'($urandom_range(4800, 8191));
            else if ($urandom_range(0, 3) == 0) ra = 13'($urandom_range(0, 4799));
            else ra = 13'($urandom_range(160, 639));
            do_write(ra, 8'($urandom));
        end
        wait_out(62 * 800);

        // Reset mid-frame.
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("reset_mid_frame", 64'({hsync, vsync, valid, frame_start, busy, ascii, x, y}),
              64'({1'b1, 1'b1, 31'd0}));
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check("frame_start_after_reset", 64'(frame_start), 64'd1);

        // Reset mid-clear.
        pulse_clear();
        repeat (1000) @(negedge clk);
        clrn = 1'b0;
        #1;
        check("reset_mid_clear", 64'({hsync, vsync, valid, frame_start, busy, ascii, x, y}),
              64'({1'b1, 1'b1, 31'd0}));
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (3) @(negedge clk);
        check("busy_after_release", 64'(busy), 64'd0);
        wait_out(2 * 800 + 100);
        check("row0_blank", 64'({ascii, x, y}), 64'({8'h20, 10'd4, 10'd2}));

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vga_text_ctrl.md
VGA_TEXT_CTRL -- requirements
Module: vga_text_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and clrn.
REQ-002 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-004 Parameter COLS, default 80: character columns; ROWS, default 60: character rows; cell size is fixed at 8x8 pixels.
REQ-005 Ports SHALL be exactly:
- clk  in  1  pixel clock
- clrn  in  1  async active-low reset
- wr_en  in  1  character write strobe
- wr_addr  in  13  character index, row*COLS+col
- wr_data  in  8  ASCII code to store
- clear_req  in  1  request to fill the screen with blanks
- busy  out  1  clear in progress
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- valid  out  1  current pixel is in the active area
- frame_start  out  1  one-cycle pulse on pixel (0,0)
- ascii  out  8  character at the current pixel, to char_display
- x  out  10  pixel column within the cell (0..7), to char_display
- y  out  10  pixel row within the cell (0..7), to char_display

Function
REQ-006 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment when h_cnt wraps, counting 0..524 and wrapping to 0.
REQ-007 Active area: h_cnt<640 and v_cnt<480. hsync is low for h_cnt 656..751. vsync is low for v_cnt 490..491.
REQ-008 Read address SHALL be (v_cnt>>3)*COLS + (h_cnt>>3), presented to a synchronous RAM holding COLS*ROWS (4800) bytes.
REQ-009 All outputs SHALL be registered and aligned to the RAM data: every output reflects counter state (h_cnt,v_cnt) exactly 1 cycle later.
REQ-010 When active: ascii = RAM[addr], x = h_cnt[2:0] zero-extended, y = v_cnt[2:0] zero-extended, valid=1.
REQ-011 When not active: ascii=0, x=0, y=0, valid=0; hsync and vsync still follow REQ-007.
REQ-012 frame_start SHALL be 1 for exactly the cycle in which outputs correspond to (0,0).
REQ-013 In IDLE with wr_en=1 and wr_addr<4800, wr_data SHALL be written at the clock edge. If wr_addr>=4800, the write SHALL be dropped.
REQ-014 A same-cycle read and write to one address SHALL return the old data (read-first).
REQ-015 State machine IDLE/CLEAR: clear_req=1 in IDLE moves to CLEAR. CLEAR writes 8'h20 to addresses 0..4799, one per cycle, then returns to IDLE.
REQ-016 busy SHALL be 1 in the cycle after clear_req is accepted and stay 1 for exactly 4800 cycles.
REQ-017 While busy: wr_en and clear_req SHALL be ignored, and display reads SHALL continue.

Reset
REQ-018 While clrn=0: h_cnt=0, v_cnt=0, state=IDLE, clear counter=0, hsync=1, vsync=1, valid=0, frame_start=0, ascii=0, x=0, y=0, busy=0.
REQ-019 RAM contents SHALL NOT be reset. Reset asserted during CLEAR SHALL abort the clear.
REQ-020 The first frame_start SHALL occur 1 cycle after clrn deasserts.

Structure
REQ-021 Package vga_text_pkg SHALL hold: H_TOTAL=800, H_SYNC_START=656, H_SYNC_END=751, V_TOTAL=525, V_SYNC_START=490, V_SYNC_END=491, CHAR_BLANK=8'h20, and the state encoding.
REQ-022 Sub-module text_ram SHALL be a single-clock memory with one write port and one registered, read-first read port; it has no reset.

Verification
REQ-023 Release reset, then run 800*525 cycles -> frame_start pulses exactly once per 420000 cycles; hsync low for 96 cycles per line; vsync low for 1600 cycles per frame.
REQ-024 Write 8'h41 to addr 0 and 8'h42 to addr 81 -> at output pixel (3,2): ascii=41, x=3, y=2; at pixel (10,9): ascii=42, x=2, y=1.
REQ-025 Write to wr_addr 4800 with data 8'h44 -> no RAM location changes; ascii never equals 44 during a full frame.
REQ-026 Pulse clear_req -> busy high for 4800 cycles; a wr_en during busy is dropped; afterwards every active pixel shows ascii=20.
REQ-027 Assert clrn mid-frame and mid-clear -> all outputs take the REQ-018 values immediately; busy=0 after release.
REQ-028 Blanking region (h_cnt=700) -> valid=0, ascii=0, x=0, y=0.
